// File: rtl/pmu_pkg.sv
// Shared PMU definitions: domain count, domain indices, sequencer states
// and default sequencing delays.
package pmu_pkg;

    localparam int NUM_PD = 10;
    localparam int PD_W   = $clog2(NUM_PD);

    // Default sequencing delays, in core clock cycles
    localparam int T_ISO_DEF    = 4;
    localparam int T_RET_DEF    = 8;
    localparam int T_ACK_TO_DEF = 64;
    localparam int CNT_W_DEF    = 16;

    // Power domain indices
    localparam int PD_RTC  = 0;
    localparam int PD_AON  = 1;
    localparam int PD_CPU0 = 2;
    localparam int PD_CPU1 = 3;
    localparam int PD_GPU  = 4;
    localparam int PD_DSP  = 5;
    localparam int PD_MEM  = 6;
    localparam int PD_IO   = 7;
    localparam int PD_PERI = 8;
    localparam int PD_DBG  = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DN_ISO = 3'd1,
        DN_RET = 3'd2,
        DN_SW  = 3'd3,
        UP_SW  = 3'd4,
        UP_RES = 3'd5,
        DONE   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/pmu_rr_arbiter.sv
// Combinational round-robin pick: first pending slot at or after rr_ptr,
// wrapping at N. Usable by any PMU scheduler.
module pmu_rr_arbiter
    import pmu_pkg::*;
#(
    parameter int N  = NUM_PD,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    localparam int CW = IW + 1;

    // Scan all N slots starting from rr_ptr; the first pending slot wins.
    always_comb begin
        logic [CW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!valid && pending[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pmu_pd_sequencer.sv
// Power-switch sequencing engine: serves one domain at a time, round-robin,
// driving isolation, retention and switch enable, and closing the loop on
// the switch acknowledge with a per-domain timeout fault.
//
// Switch handshake: pd_sw_en[i] is a level request and pd_sw_ack[i] the
// level status of the switch chain; a step completes when ack equals the
// requested level, there is no separate valid/ready pair.
module pmu_pd_sequencer
    import pmu_pkg::*;
#(
    parameter int T_ISO    = T_ISO_DEF,
    parameter int T_RET    = T_RET_DEF,
    parameter int T_ACK_TO = T_ACK_TO_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_PD-1:0] pd_req,
    input  logic [NUM_PD-1:0] pd_ret_en,
    input  logic [NUM_PD-1:0] pd_sw_ack,
    input  logic              err_clr,
    output logic [NUM_PD-1:0] pd_sw_en,
    output logic [NUM_PD-1:0] pd_iso_n,
    output logic [NUM_PD-1:0] pd_ret_n,
    output logic [NUM_PD-1:0] pd_status,
    output logic [NUM_PD-1:0] pd_fault,
    output logic              busy,
    output logic [PD_W-1:0]   cur_pd,
    output logic              timeout_err,
    output seq_state_e        dbg_state
);

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(T_ISO - 1);
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(T_RET - 1);
    // Restore window also covers the cycle in which ack is first seen high
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(T_RET);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(T_ACK_TO - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  timer_q;
    logic [PD_W-1:0]   idx_q, rr_ptr_q, arb_idx, tgt;
    logic              ret_en_q, arb_valid, ack_cur;
    logic [NUM_PD-1:0] sw_en_q, iso_n_q, ret_n_q, status_q, fault_q, pending;
    logic              timeout_q;

    // Per-step strobes from the FSM, applied to domain tgt
    logic dispatch, sw_on, sw_off, iso_clamp, iso_release;
    logic ret_save, ret_restore, st_up, st_down, flt;

    assign pending = (pd_req ^ status_q) & ~fault_q;
    assign tgt     = (state_q == IDLE) ? arb_idx : idx_q;
    assign ack_cur = pd_sw_ack[idx_q];

    pmu_rr_arbiter #(
        .N  (NUM_PD),
        .IW (PD_W)
    ) u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr_q),
        .valid   (arb_valid),
        .idx     (arb_idx)
    );

    // Next-state logic and per-step strobes for the sequence in progress.
    always_comb begin
        state_d     = state_q;
        dispatch    = 1'b0;
        sw_on       = 1'b0;
        sw_off      = 1'b0;
        iso_clamp   = 1'b0;
        iso_release = 1'b0;
        ret_save    = 1'b0;
        ret_restore = 1'b0;
        st_up       = 1'b0;
        st_down     = 1'b0;
        flt         = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    dispatch = 1'b1;
                    if (pd_req[arb_idx]) begin
                        state_d = UP_SW;
                        sw_on   = 1'b1;
                    end else begin
                        state_d   = DN_ISO;
                        iso_clamp = 1'b1;
                    end
                end
            end
            DN_ISO: begin
                if (timer_q == ISO_LAST) begin
                    if (ret_en_q) begin
                        state_d  = DN_RET;
                        ret_save = 1'b1;
                    end else begin
                        state_d = DN_SW;
                        sw_off  = 1'b1;
                    end
                end
            end
            DN_RET: begin
                if (timer_q == RET_LAST) begin
                    state_d = DN_SW;
                    sw_off  = 1'b1;
                end
            end
            DN_SW: begin
                if (!ack_cur) begin
                    state_d = DONE;
                    st_down = 1'b1;
                end else if (timer_q == ACK_LAST) begin
                    state_d = DONE;
                    flt     = 1'b1;
                end
            end
            UP_SW: begin
                if (ack_cur) begin
                    state_d     = UP_RES;
                    ret_restore = 1'b1;
                end else if (timer_q == ACK_LAST) begin
                    state_d = DONE;
                    flt     = 1'b1;
                    sw_off  = 1'b1;
                end
            end
            UP_RES: begin
                if (timer_q == RES_LAST) begin
                    state_d     = DONE;
                    iso_release = 1'b1;
                    st_up       = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, timer, arbitration pointer and per-domain output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            ret_en_q  <= 1'b0;
            sw_en_q   <= '0;
            iso_n_q   <= '0;
            ret_n_q   <= '1;
            status_q  <= '0;
            fault_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
            if (dispatch) begin
                idx_q    <= arb_idx;
                rr_ptr_q <= (arb_idx == PD_W'(NUM_PD - 1)) ? '0 : arb_idx + 1'b1;
                ret_en_q <= pd_ret_en[arb_idx];
            end
            if (sw_on)       sw_en_q[tgt]  <= 1'b1;
            if (sw_off)      sw_en_q[tgt]  <= 1'b0;
            if (iso_clamp)   iso_n_q[tgt]  <= 1'b0;
            if (iso_release) iso_n_q[tgt]  <= 1'b1;
            if (ret_save)    ret_n_q[tgt]  <= 1'b0;
            if (ret_restore) ret_n_q[tgt]  <= 1'b1;
            if (st_up)       status_q[tgt] <= 1'b1;
            if (st_down)     status_q[tgt] <= 1'b0;
            // A timeout landing in the same cycle as err_clr stays recorded
            if (err_clr) begin
                fault_q   <= '0;
                timeout_q <= 1'b0;
            end
            if (flt) begin
                fault_q[tgt] <= 1'b1;
                timeout_q    <= 1'b1;
            end
        end
    end

    assign pd_sw_en    = sw_en_q;
    assign pd_iso_n    = iso_n_q;
    assign pd_ret_n    = ret_n_q;
    assign pd_status   = status_q;
    assign pd_fault    = fault_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != IDLE);
    assign cur_pd      = busy ? idx_q : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pmu_pd_sequencer.sv
// Directed bench for pmu_pd_sequencer with a two-cycle switch-chain model.
module tb_pmu_pd_sequencer;
    import pmu_pkg::*;

    logic       clk;
    logic       rstn;
    logic [9:0] pd_req, pd_ret_en, pd_sw_ack;
    logic       err_clr;
    logic [9:0] pd_sw_en, pd_iso_n, pd_ret_n, pd_status, pd_fault;
    logic       busy, timeout_err;
    logic [3:0] cur_pd;
    seq_state_e dbg_state;

    logic [9:0] ack_d1, ack_stuck0;
    int checks = 0;
    int errors = 0;

    pmu_pd_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .pd_req      (pd_req),
        .pd_ret_en   (pd_ret_en),
        .pd_sw_ack   (pd_sw_ack),
        .err_clr     (err_clr),
        .pd_sw_en    (pd_sw_en),
        .pd_iso_n    (pd_iso_n),
        .pd_ret_n    (pd_ret_n),
        .pd_status   (pd_status),
        .pd_fault    (pd_fault),
        .busy        (busy),
        .cur_pd      (cur_pd),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Switch chain: ack follows sw_en two cycles later; stuck bits never ack.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_d1    <= '0;
            pd_sw_ack <= '0;
        end else begin
            ack_d1    <= pd_sw_en;
            pd_sw_ack <= ack_d1 & ~ack_stuck0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        pd_req     = '0;
        pd_ret_en  = '0;
        err_clr    = 1'b0;
        ack_stuck0 = '0;
        tick(3);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic wait_settle(input logic [9:0] exp, input int budget, input string name);
        int n;
        n = 0;
        while (!(!busy && pd_status === exp) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy || pd_status !== exp) begin
            errors++;
            $display("FAIL %s settle: status %h busy %b, required status %h busy 0", name, pd_status, busy, exp);
        end
    endtask

    task automatic test_reset();
        logic seen_busy;
        do_reset();
        checks++; if (pd_sw_en !== 10'h000) begin errors++; $display("FAIL rst_sw_en: got %h exp 000", pd_sw_en); end
        checks++; if (pd_iso_n !== 10'h000) begin errors++; $display("FAIL rst_iso_n: got %h exp 000", pd_iso_n); end
        checks++; if (pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL rst_ret_n: got %h exp 3ff", pd_ret_n); end
        checks++; if (pd_status !== 10'h000) begin errors++; $display("FAIL rst_status: got %h exp 000", pd_status); end
        checks++; if (pd_fault !== 10'h000 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_fault: got %h/%b exp 000/0", pd_fault, timeout_err); end
        checks++; if (cur_pd !== 4'd0) begin errors++; $display("FAIL rst_cur_pd: got %0d exp 0", cur_pd); end
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0) seen_busy = 1'b1;
            tick(1);
        end
        checks++; if (seen_busy) begin errors++; $display("FAIL rst_idle: busy seen 1, required 0 for 20 cycles"); end
    endtask

    task automatic test_power_up();
        pd_req = 10'h008;
        tick(1);
        checks++; if (pd_sw_en !== 10'h008) begin errors++; $display("FAIL up_sw_en: got %h exp 008", pd_sw_en); end
        checks++; if (busy !== 1'b1 || cur_pd !== 4'd3) begin errors++; $display("FAIL up_busy: got %b/%0d exp 1/3", busy, cur_pd); end
        tick(11);
        checks++; if (pd_iso_n !== 10'h000 || pd_status !== 10'h000) begin errors++; $display("FAIL up_early: iso %h status %h exp 000/000", pd_iso_n, pd_status); end
        tick(1);
        checks++; if (pd_iso_n !== 10'h008 || pd_status !== 10'h008) begin errors++; $display("FAIL up_release: iso %h status %h exp 008/008", pd_iso_n, pd_status); end
        checks++; if (pd_sw_en !== 10'h008 || pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL up_others: sw %h ret %h exp 008/3ff", pd_sw_en, pd_ret_n); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_idle: busy %b exp 0", busy); end
    endtask

    task automatic test_power_down();
        // Retention enabled
        pd_req    = 10'h000;
        pd_ret_en = 10'h008;
        tick(1);
        checks++; if (pd_iso_n !== 10'h000 || pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL dn_iso: iso %h ret %h exp 000/3ff", pd_iso_n, pd_ret_n); end
        tick(3);
        checks++; if (pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL dn_ret_early: ret %h exp 3ff", pd_ret_n); end
        tick(1);
        checks++; if (pd_ret_n !== 10'h3F7) begin errors++; $display("FAIL dn_ret: ret %h exp 3f7", pd_ret_n); end
        tick(7);
        checks++; if (pd_sw_en !== 10'h008) begin errors++; $display("FAIL dn_sw_early: sw %h exp 008", pd_sw_en); end
        tick(1);
        checks++; if (pd_sw_en !== 10'h000 || pd_status !== 10'h008) begin errors++; $display("FAIL dn_sw: sw %h status %h exp 000/008", pd_sw_en, pd_status); end
        tick(2);
        checks++; if (pd_status !== 10'h008) begin errors++; $display("FAIL dn_status_early: status %h exp 008", pd_status); end
        tick(1);
        checks++; if (pd_status !== 10'h000 || pd_ret_n !== 10'h3F7) begin errors++; $display("FAIL dn_status: status %h ret %h exp 000/3f7", pd_status, pd_ret_n); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dn_idle: busy %b exp 0", busy); end
        // Back up, then down without retention
        pd_req = 10'h008;
        wait_settle(10'h008, 40, "dn_reup");
        checks++; if (pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL dn_restore: ret %h exp 3ff", pd_ret_n); end
        pd_req    = 10'h000;
        pd_ret_en = 10'h000;
        tick(1);
        checks++; if (pd_iso_n !== 10'h000) begin errors++; $display("FAIL dn2_iso: iso %h exp 000", pd_iso_n); end
        tick(3);
        checks++; if (pd_sw_en !== 10'h008) begin errors++; $display("FAIL dn2_sw_early: sw %h exp 008", pd_sw_en); end
        tick(1);
        checks++; if (pd_sw_en !== 10'h000 || pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL dn2_sw: sw %h ret %h exp 000/3ff", pd_sw_en, pd_ret_n); end
        tick(3);
        checks++; if (pd_status !== 10'h000 || pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL dn2_status: status %h ret %h exp 000/3ff", pd_status, pd_ret_n); end
    endtask

    task automatic test_all_domains();
        int         order[$];
        logic       busy_prev;
        logic [3:0] pd_prev;
        logic [9:0] sw_prev;
        do_reset();
        busy_prev = 1'b0;
        pd_prev   = '0;
        sw_prev   = pd_sw_en;
        pd_req    = 10'h3FF;
        for (int c = 0; c < 400; c++) begin
            tick(1);
            checks++;
            if (((pd_iso_n & ~(pd_sw_en & pd_ret_n)) != 10'h000) || ((sw_prev & ~pd_sw_en & pd_iso_n) != 10'h000)) begin
                errors++;
                $display("FAIL all_invariant: sw %h iso %h ret %h prev_sw %h", pd_sw_en, pd_iso_n, pd_ret_n, sw_prev);
            end
            checks++;
            if (busy && busy_prev && cur_pd !== pd_prev) begin
                errors++;
                $display("FAIL all_gap: cur_pd %0d changed from %0d without an idle gap", cur_pd, pd_prev);
            end
            if (busy && !busy_prev) order.push_back(int'(cur_pd));
            busy_prev = busy;
            pd_prev   = cur_pd;
            sw_prev   = pd_sw_en;
            if (order.size() == 10 && !busy) break;
        end
        checks++; if (order.size() != 10) begin errors++; $display("FAIL all_count: %0d dispatches, required 10", order.size()); end
        for (int k = 0; k < order.size(); k++) begin
            checks++; if (order[k] != k) begin errors++; $display("FAIL all_order: slot %0d served %0d, required %0d", k, order[k], k); end
        end
        checks++; if (pd_status !== 10'h3FF || pd_iso_n !== 10'h3FF) begin errors++; $display("FAIL all_final: status %h iso %h exp 3ff/3ff", pd_status, pd_iso_n); end
    endtask

    task automatic test_timeout();
        logic seen_busy;
        do_reset();
        ack_stuck0 = 10'h020;
        pd_req     = 10'h020;
        tick(1);
        checks++; if (pd_sw_en !== 10'h020 || cur_pd !== 4'd5) begin errors++; $display("FAIL to_start: sw %h cur %0d exp 020/5", pd_sw_en, cur_pd); end
        tick(63);
        checks++; if (pd_fault !== 10'h000 || pd_sw_en !== 10'h020) begin errors++; $display("FAIL to_early: fault %h sw %h exp 000/020", pd_fault, pd_sw_en); end
        tick(1);
        checks++; if (pd_fault !== 10'h020 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_fault: fault %h err %b exp 020/1", pd_fault, timeout_err); end
        checks++; if (pd_sw_en !== 10'h000 || pd_iso_n !== 10'h000 || pd_status !== 10'h000) begin errors++; $display("FAIL to_outputs: sw %h iso %h status %h exp 000/000/000", pd_sw_en, pd_iso_n, pd_status); end
        tick(2);
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0) seen_busy = 1'b1;
            tick(1);
        end
        checks++; if (seen_busy) begin errors++; $display("FAIL to_no_retry: busy seen 1, required 0"); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (pd_fault !== 10'h000 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: fault %h err %b exp 000/0", pd_fault, timeout_err); end
        tick(1);
        checks++; if (busy !== 1'b1 || cur_pd !== 4'd5 || pd_sw_en !== 10'h020) begin errors++; $display("FAIL to_retry: busy %b cur %0d sw %h exp 1/5/020", busy, cur_pd, pd_sw_en); end
        ack_stuck0 = 10'h000;
        wait_settle(10'h020, 80, "to_recover");
    endtask

    task automatic test_req_change_reset();
        do_reset();
        pd_req = 10'h004;
        tick(4);
        pd_req = 10'h000;
        tick(9);
        checks++; if (pd_status !== 10'h004 || pd_iso_n !== 10'h004) begin errors++; $display("FAIL chg_up_done: status %h iso %h exp 004/004", pd_status, pd_iso_n); end
        tick(2);
        checks++; if (busy !== 1'b1 || cur_pd !== 4'd2 || pd_iso_n !== 10'h000) begin errors++; $display("FAIL chg_down: busy %b cur %0d iso %h exp 1/2/000", busy, cur_pd, pd_iso_n); end
        tick(1);
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (pd_sw_en !== 10'h000 || pd_status !== 10'h000) begin errors++; $display("FAIL arst_sw: sw %h status %h exp 000/000", pd_sw_en, pd_status); end
        checks++; if (pd_iso_n !== 10'h000 || pd_ret_n !== 10'h3FF) begin errors++; $display("FAIL arst_iso: iso %h ret %h exp 000/3ff", pd_iso_n, pd_ret_n); end
        checks++; if (busy !== 1'b0 || cur_pd !== 4'd0) begin errors++; $display("FAIL arst_busy: busy %b cur %0d exp 0/0", busy, cur_pd); end
        tick(2);
        rstn = 1'b1;
        tick(2);
    endtask

    initial begin
        rstn       = 1'b0;
        pd_req     = '0;
        pd_ret_en  = '0;
        err_clr    = 1'b0;
        ack_stuck0 = '0;
        test_reset();
        test_power_up();
        test_power_down();
        test_all_domains();
        test_timeout();
        test_req_change_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
